// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache refills and dcache refills/write-backs,
// one line burst at a time. Optional macro ARB_ROUND_ROBIN_EN enables fair arbitration.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ic_req,
  input  logic [31:0]                   ic_addr,
  output logic [31:0]                   ic_rdata,
  output logic                          ic_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] ic_widx,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [31:0]                   dc_addr,
  input  logic [31:0]                   dc_wdata,
  output logic [$clog2(LINE_WORDS)-1:0] dc_widx,
  output logic [31:0]                   dc_rdata,
  output logic                          dc_rvalid,
  output logic                          dc_done,
  output logic [31:0]                   mem_addr,
  output logic                          mem_we,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic                          busy,
  output logic [1:0]                    grant
);

  localparam int IW  = $clog2(LINE_WORDS);
  localparam int OFF = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t          state;
  logic [31:OFF]   base;
  logic [IW-1:0]   cnt;
  logic            issuing;
  logic [MEM_LAT-1:0] vld;
  logic [IW-1:0]   idx [MEM_LAT];

  logic pick_dc, pick_ic;
  logic issue, wr, rv, last_rv;
  logic [IW-1:0] rv_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;  // 0 = icache, 1 = dcache
  assign pick_dc = dc_req && (!ic_req || !last_owner);
`else
  assign pick_dc = dc_req;
`endif
  assign pick_ic = ic_req && !pick_dc;

  assign issue   = (state == READ) && issuing;
  assign wr      = (state == WRITE);
  assign rv      = vld[MEM_LAT-1];
  assign rv_idx  = idx[MEM_LAT-1];
  assign last_rv = rv && (rv_idx == LAST);

  // NOTE: outputs are decoded from registered state, so the async reset zeroes them without a clock.
  assign ic_rvalid = rv && grant[0];
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_widx   = ic_rvalid ? rv_idx : '0;
  assign ic_done   = grant[0] && last_rv;

  assign dc_rvalid = rv && grant[1];
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_widx   = wr ? cnt : (dc_rvalid ? rv_idx : '0);
  assign dc_done   = grant[1] && (last_rv || (wr && cnt == LAST));

  assign mem_we    = wr;
  assign mem_addr  = (issue || wr) ? {base, cnt, 2'b00} : '0;
  assign mem_wdata = wr ? dc_wdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[OFF-1:0], dc_addr[OFF-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      base    <= '0;
      cnt     <= '0;
      issuing <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_dc || pick_ic) begin
            grant   <= {pick_dc, pick_ic};
            busy    <= 1'b1;
            base    <= pick_dc ? dc_addr[31:OFF] : ic_addr[31:OFF];
            cnt     <= '0;
            issuing <= !(pick_dc && dc_we);
            state   <= (pick_dc && dc_we) ? WRITE : READ;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= pick_dc;
`endif
          end
        end
        READ: begin
          if (issuing) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) issuing <= 1'b0;
          end
          if (last_rv) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return-tag pipeline: one stage per cycle of memory latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      // NOTE: the tag pipeline is cleared too, so a stale index can never surface after reset.
      for (int s = 0; s < MEM_LAT; s++) idx[s] <= '0;
    end else begin
      vld[0] <= issue;
      idx[0] <= cnt;
      for (int s = 1; s < MEM_LAT; s++) begin
        vld[s] <= vld[s-1];
        idx[s] <= idx[s-1];
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a MEM_LAT=1 instance plus a MEM_LAT=3 instance.
module tb_cache_mem_arbiter;

  localparam int LW = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst;
  logic ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata, ic_rdata, dc_rdata;
  logic ic_rvalid, ic_done, dc_rvalid, dc_done, mem_we, busy;
  logic [1:0] ic_widx, dc_widx, grant;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, a1;

  logic s3_ic_req;
  logic [31:0] s3_ic_addr, s3_ic_rdata, s3_dc_rdata, s3_mem_addr, s3_mem_wdata, s3_mem_rdata;
  logic s3_ic_rvalid, s3_ic_done, s3_dc_rvalid, s3_dc_done, s3_mem_we, s3_busy;
  logic [1:0] s3_ic_widx, s3_dc_widx, s3_grant;
  logic [31:0] b1, b2, b3;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
    bit          done;
  } exp_t;

  exp_t iss_q[$], ic_q[$], dc_q[$], wr_q[$], iss3_q[$], ic3_q[$];
  exp_t e, e3;
  int n_chk = 0, n_pass = 0, cyc = 0, rv3_cnt = 0;
  bit tb_last;

  cache_mem_arbiter #(.LINE_WORDS(LW), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
    .ic_widx(ic_widx), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_widx(dc_widx), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant));

  cache_mem_arbiter #(.LINE_WORDS(LW), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .ic_req(s3_ic_req), .ic_addr(s3_ic_addr), .ic_rdata(s3_ic_rdata), .ic_rvalid(s3_ic_rvalid),
    .ic_widx(s3_ic_widx), .ic_done(s3_ic_done),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(32'h0), .dc_wdata(32'h0),
    .dc_widx(s3_dc_widx), .dc_rdata(s3_dc_rdata), .dc_rvalid(s3_dc_rvalid), .dc_done(s3_dc_done),
    .mem_addr(s3_mem_addr), .mem_we(s3_mem_we), .mem_wdata(s3_mem_wdata), .mem_rdata(s3_mem_rdata),
    .busy(s3_busy), .grant(s3_grant));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory models with fixed read latency, and the write-back source array.
  always @(posedge clk) begin
    a1 <= mem_addr;
    b1 <= s3_mem_addr; b2 <= b1; b3 <= b2;
  end
  assign mem_rdata    = mdata(a1);
  assign s3_mem_rdata = mdata(b3);
  assign dc_wdata     = 32'h0000_00A0 + 32'(dc_widx);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_read(input bit to_dc, input bit inst3, input logic [31:0] addr,
                           input int t, input int lat);
    exp_t x;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int k = 0; k < LW; k++) begin
      x.cyc = t + 1 + k; x.a = base + 32'(4 * k); x.d = 0; x.idx = 0; x.done = 0;
      if (inst3) iss3_q.push_back(x); else iss_q.push_back(x);
      x.cyc = t + 1 + k + lat; x.d = mdata(base + 32'(4 * k)); x.idx = k; x.done = (k == LW - 1);
      if (inst3) ic3_q.push_back(x);
      else if (to_dc) dc_q.push_back(x);
      else ic_q.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ic_refill(input logic [31:0] addr, input bit twice);
    int t, d;
    t = cyc; ic_addr = addr; ic_req = 1'b1;
    push_read(1'b0, 1'b0, addr, t, 1);
    d = t + LW + 1;
    if (twice) begin
      push_read(1'b0, 1'b0, addr, d + 1, 1);
      d = d + 1 + LW + 1;
    end
    wait_cyc(d + 1);
    ic_req = 1'b0; tb_last = 1'b0;
  endtask

  task automatic dc_write(input logic [31:0] addr);
    exp_t x;
    int t;
    t = cyc; dc_addr = addr; dc_we = 1'b1; dc_req = 1'b1;
    for (int k = 0; k < LW; k++) begin
      x.cyc = t + 1 + k; x.a = addr + 32'(4 * k); x.d = 32'hA0 + 32'(k);
      x.idx = k; x.done = (k == LW - 1);
      wr_q.push_back(x);
    end
    wait_cyc(t + LW + 1);
    dc_req = 1'b0; dc_we = 1'b0; tb_last = 1'b1;
  endtask

  task automatic contend(input logic [31:0] ia, input logic [31:0] da);
    int t, d1, d2;
    bit first_dc;
    first_dc = RR ? !tb_last : 1'b1;
    t = cyc; ic_addr = ia; dc_addr = da; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
    d1 = t + LW + 1;
    d2 = d1 + 1 + LW + 1;
    push_read(first_dc, 1'b0, first_dc ? da : ia, t, 1);
    push_read(!first_dc, 1'b0, first_dc ? ia : da, d1 + 1, 1);
    wait_cyc(d1 + 1);
    if (first_dc) dc_req = 1'b0; else ic_req = 1'b0;
    wait_cyc(d2 + 1);
    ic_req = 1'b0; dc_req = 1'b0;
    tb_last = !first_dc;
  endtask

  // Monitor for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    if (busy) check("grant_excl", grant[0] & grant[1], 0);
    if (mem_addr != 0 && !mem_we) begin
      check("iss_expected", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        e = iss_q.pop_front();
        check("iss_cyc", cyc, e.cyc);
        check("iss_addr", mem_addr, e.a);
      end
    end
    if (ic_rvalid) begin
      check("ic_expected", ic_q.size() != 0, 1);
      if (ic_q.size() != 0) begin
        e = ic_q.pop_front();
        check("ic_cyc", cyc, e.cyc);
        check("ic_rdata", ic_rdata, e.d);
        check("ic_widx", ic_widx, e.idx);
        check("ic_done", ic_done, e.done);
        check("ic_grant", grant, 2'b01);
        check("dc_side_quiet", {dc_rvalid, dc_done, dc_rdata, dc_widx}, 0);
      end
    end
    if (dc_rvalid) begin
      check("dc_expected", dc_q.size() != 0, 1);
      if (dc_q.size() != 0) begin
        e = dc_q.pop_front();
        check("dc_cyc", cyc, e.cyc);
        check("dc_rdata", dc_rdata, e.d);
        check("dc_widx", dc_widx, e.idx);
        check("dc_done", dc_done, e.done);
        check("dc_grant", grant, 2'b10);
        check("ic_side_quiet", {ic_rvalid, ic_done, ic_rdata, ic_widx}, 0);
      end
    end
    if (mem_we) begin
      check("wr_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_cyc", cyc, e.cyc);
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_wdata, e.d);
        check("wr_widx", dc_widx, e.idx);
        check("wr_done", dc_done, e.done);
        check("wr_grant", grant, 2'b10);
        check("wr_no_rvalid", dc_rvalid, 0);
      end
    end
    if (ic_done) check("ic_done_with_rvalid", ic_rvalid, 1);
    if (dc_done) check("dc_done_with_word", dc_rvalid | mem_we, 1);
  end

  // Monitor for the MEM_LAT=3 instance.
  always @(negedge clk) begin
    if (s3_mem_addr != 0) begin
      check("s3_iss_expected", iss3_q.size() != 0, 1);
      if (iss3_q.size() != 0) begin
        e3 = iss3_q.pop_front();
        check("s3_iss_cyc", cyc, e3.cyc);
        check("s3_iss_addr", s3_mem_addr, e3.a);
      end
    end
    if (s3_ic_rvalid) begin
      rv3_cnt++;
      check("s3_ic_expected", ic3_q.size() != 0, 1);
      if (ic3_q.size() != 0) begin
        e3 = ic3_q.pop_front();
        check("s3_ic_cyc", cyc, e3.cyc);
        check("s3_ic_rdata", s3_ic_rdata, e3.d);
        check("s3_ic_widx", s3_ic_widx, e3.idx);
        check("s3_ic_done", s3_ic_done, e3.done);
      end
    end
    if (s3_ic_done) check("s3_done_with_rvalid", s3_ic_rvalid, 1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; s3_ic_req = 1'b0; s3_ic_addr = '0; tb_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {grant, busy, mem_we, ic_rvalid, ic_done, dc_rvalid, dc_done}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check("rst_s3", {s3_grant, s3_busy, s3_mem_addr}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    contend(32'h0000_4000, 32'h0000_3000);
    @(posedge clk); #1;
    ic_refill(32'h0000_104C, 1'b0);
    @(posedge clk); #1;
    dc_write(32'h0000_2000);
    @(posedge clk); #1;
    contend(32'h0000_6000, 32'h0000_7000);
    @(posedge clk); #1;
    ic_refill(32'h0000_104C, 1'b1);
    @(posedge clk); #1;

    // Reset while word 2 is in flight: only word 0 is ever returned.
    t = cyc; ic_addr = 32'h0000_8000; ic_req = 1'b1;
    iss_q.push_back('{t + 1, 32'h0000_8000, 32'h0, 0, 1'b0});
    iss_q.push_back('{t + 2, 32'h0000_8004, 32'h0, 0, 1'b0});
    ic_q.push_back('{t + 2, 32'h0000_8000, mdata(32'h0000_8000), 0, 1'b0});
    wait_cyc(t + 3);
    #1;
    rst = 1'b0; ic_req = 1'b0;
    #1;
    check("async_rst_ic", {ic_rvalid, ic_done, ic_rdata, ic_widx}, 0);
    check("async_rst_ctrl", {grant, busy, mem_we, dc_rvalid, dc_done, dc_widx}, 0);
    check("async_rst_mem", {mem_addr, mem_wdata}, 0);
    tb_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", {grant, busy}, 0);

    // MEM_LAT=3 refill: drains three cycles with no addresses.
    t = cyc; s3_ic_addr = 32'h0000_9004; s3_ic_req = 1'b1;
    push_read(1'b0, 1'b1, 32'h0000_9004, t, 3);
    wait_cyc(t + 5);
    for (int k = 0; k < 3; k++) begin
      check("s3_drain_addr", s3_mem_addr, 0);
      @(posedge clk); #1;
    end
    wait_cyc(t + 8);
    s3_ic_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s3_grant_released", s3_grant, 0);
    check("s3_rvalid_count", rv3_cnt, 4);
    check("iss_q_empty", iss_q.size(), 0);
    check("ic_q_empty", ic_q.size(), 0);
    check("dc_q_empty", dc_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("s3_q_empty", iss3_q.size() + ic3_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single synchronous main-memory port between the instruction cache (line refill) and the data cache (line refill and line write-back). It sits between both caches and the memory. It sequences each burst word by word, handles the memory's fixed read latency, and returns data tagged with its word index. One transaction is in flight at a time; the requester not granted simply waits.

## Interface
Parameters:
- `LINE_WORDS`, 4 — words per cache line; power of two, 2..16.
- `MEM_LAT`, 1 — memory read latency in cycles, 1..4.

Ports:
- `clk` in 1 — clock; all state on rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `ic_req` in 1 — icache line-refill request; level, held until `ic_done`.
- `ic_addr` in 32 — icache byte address; the arbiter uses the line base.
- `ic_rdata` out 32 — refill data word.
- `ic_rvalid` out 1 — `ic_rdata` is valid this cycle.
- `ic_widx` out log2(LINE_WORDS) — word index of `ic_rdata`.
- `ic_done` out 1 — one-cycle pulse with the last refill word.
- `dc_req` in 1 — dcache request; level, held until `dc_done`.
- `dc_we` in 1 — 1 = line write-back, 0 = line refill; stable while `dc_req` is high.
- `dc_addr` in 32 — dcache byte address; the arbiter uses the line base.
- `dc_wdata` in 32 — write word for index `dc_widx`; combinational from the cache array.
- `dc_widx` out log2(LINE_WORDS) — word index being written or returned.
- `dc_rdata` out 32 — refill data word.
- `dc_rvalid` out 1 — `dc_rdata` is valid this cycle.
- `dc_done` out 1 — one-cycle pulse marking the end of the transaction.
- `mem_addr` out 32 — memory byte address, word aligned.
- `mem_we` out 1 — memory write enable.
- `mem_wdata` out 32 — memory write data.
- `mem_rdata` in 32 — memory read data, `MEM_LAT` cycles after the address.
- `busy` out 1 — a transaction is active.
- `grant` out 2 — bit0 icache owns the port, bit1 dcache owns the port; never both set.

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - Requests are evaluated only in this state.
  - Granted `dc_req` with `dc_we`=1 → WRITE; granted `dc_req` with `dc_we`=0 → READ; granted `ic_req` → READ.
  - The line base is latched at grant: address with the low log2(LINE_WORDS*4) bits cleared.
- Priority without the macro: dcache always wins on simultaneous requests.
- READ:
  - Issue counter `i` runs from 0 to LINE_WORDS-1, one address per cycle: `mem_addr` = base + 4·i.
  - A `MEM_LAT`-deep valid/index shift register tags the returning data.
  - `rvalid`/`widx`/`rdata` go to the owner only; `rdata` is `mem_rdata` passed straight through.
  - After the last issue, the FSM stays in READ with no new addresses until the last word returns.
  - The `done` pulse coincides with the last `rvalid`; the next cycle is IDLE.
- WRITE:
  - One word per cycle: `mem_we`=1, `mem_addr` = base + 4·i, `mem_wdata` = `dc_wdata`, `dc_widx` = i.
  - `dc_done` coincides with the last write; the next cycle is IDLE.
- Requester rule: a requester deasserts `req` in the cycle after `done`. A `req` still high in IDLE is a new transaction.
- Outputs with no owner, and all outputs to the non-owner: `rvalid`=0, `done`=0, `rdata`=0, `widx`=0.
- Memory outputs while IDLE or draining: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- A request dropped mid-transaction is ignored; the burst completes.
- Reset (asserted at any time): FSM to IDLE, counters and shift register cleared, in-flight data discarded, every output 0.

## Timing
- Request high in IDLE at cycle T → `grant`/`busy` asserted and word 0 issued at T+1.
- Read burst: word k returns at T+1+k+MEM_LAT; `done` at T+LINE_WORDS+MEM_LAT; IDLE again at T+LINE_WORDS+MEM_LAT+1.
- Write burst: words at T+1..T+LINE_WORDS; `dc_done` at T+LINE_WORDS.
- `grant` and `busy` are registered; they deassert in the cycle after `done`.
- Minimum gap between transactions: one IDLE cycle.
- Index arithmetic is modulo LINE_WORDS; address adds never carry into the line-base bits.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A registered `last_owner` bit, reset to icache.
  - On simultaneous requests, the requester that was not last granted wins; a lone requester always wins and updates `last_owner`.
  - The first contention after reset goes to the dcache.
- Not defined: fixed dcache priority and no `last_owner` register. The icache can starve under back-to-back dcache traffic; this is accepted.

## Test plan
All scenarios use LINE_WORDS=4, MEM_LAT=1.
- icache refill, `ic_addr`=0x0000_104C → `mem_addr` 0x1040, 0x1044, 0x1048, 0x104C at T+1..T+4. `ic_rvalid` at T+2..T+5 with `ic_widx` 0..3 matching the memory model data. `ic_done` at T+5 only.
- dcache write-back, `dc_addr`=0x2000, `dc_wdata` = 0xA0+`dc_widx` → `mem_we`=1 with words 0xA0..0xA3 at 0x2000..0x200C over T+1..T+4. `dc_done` at T+4. No `dc_rvalid`.
- `ic_req` and `dc_req` (refill) rise together → without the macro, dcache is served first and icache starts the cycle after the dcache IDLE. With `ARB_ROUND_ROBIN_EN`, the second contention grants icache first.
- Reset asserted mid-read with word 2 in flight → all outputs 0 immediately (asynchronously). No `rvalid`/`done` afterwards. `grant`=0 after release.
- Rerun with MEM_LAT=3 → `done` at T+7, `mem_addr` 0 during T+5..T+7, exactly 4 `rvalid` pulses.
- `ic_req` held high one cycle past `ic_done` → a second identical refill starts, with word 0 issued two cycles after `ic_done`.
